// File: rtl/vga_draw_scheduler_pkg.sv
// Shared definitions for the VGA draw scheduler.
// Contents:
//   state_t           - scheduler phase encoding (IDLE/BG/PAC/DONE)
//   SEL_*             - source-select codes expected by the VGA mux
//   X_W/Y_W           - adapter coordinate widths
//   SCREEN_W/SCREEN_H - visible raster size
//   CNT_W             - pixel counter width
package vga_draw_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BG   = 2'd1,
    ST_PAC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] SEL_BG   = 3'b000;
  localparam logic [2:0] SEL_PAC  = 3'b001;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int CNT_W    = 15;

endpackage

// File: rtl/vga_draw_scheduler_pixel_out_reg.sv
// Registered pixel stage feeding the vga_adapter write port.
// Ports:
//   clock, resetn          - clock, asynchronous active-low clear
//   load                   - a pixel was accepted this cycle
//   x, y, colour           - pixel selected from the granted source
//   vga_x, vga_y, vga_colour, plot - registered outputs; plot follows load
//                            by one cycle, coordinates hold while plot=0
module vga_draw_scheduler_pixel_out_reg
  import vga_draw_scheduler_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           load,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           colour,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic           vga_colour,
  output logic           plot
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= 1'b0;
      plot       <= 1'b0;
    end else begin
      plot <= load;
      if (load) begin
        vga_x      <= x;
        vga_y      <= y;
        vga_colour <= colour;
      end
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Per-frame arbiter for the single vga_adapter write port. Each accepted
// frame_tick runs an optional background pass (BG_PIXELS pixels) followed by
// a pac-man sprite pass (PAC_PIXELS pixels), then pulses frame_done.
// Ports:
//   clock, resetn              - clock, asynchronous active-low reset
//   frame_tick, full_redraw    - frame start request and pass selection
//   bg_valid/x_bg/y_bg/colour_bg, bg_grant               - background source
//   pac_valid/x_pacman/y_pacman/colour_pacman, pac_grant - sprite source
//   mux_select                 - source code for the VGA mux
//   vga_x, vga_y, vga_colour, plot - registered adapter write
//   busy, frame_done, overrun  - status (overrun is sticky until reset)
//
// Handshake: grant acts as ready. A pixel transfers in every cycle where a
// source's grant and valid are both high; grant depends only on the
// registered state, never on valid, so a source may hold valid freely and
// the non-granted source's valid has no effect.
module vga_draw_scheduler
  import vga_draw_scheduler_pkg::*;
#(
  parameter int BG_PIXELS  = 19200,
  parameter int PAC_PIXELS = 25
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic           full_redraw,
  input  logic           bg_valid,
  input  logic [X_W-1:0] x_bg,
  input  logic [Y_W-1:0] y_bg,
  input  logic           colour_bg,
  output logic           bg_grant,
  input  logic           pac_valid,
  input  logic [X_W-1:0] x_pacman,
  input  logic [Y_W-1:0] y_pacman,
  input  logic           colour_pacman,
  output logic           pac_grant,
  output logic [2:0]     mux_select,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic           vga_colour,
  output logic           plot,
  output logic           busy,
  output logic           frame_done,
  output logic           overrun
);

  localparam logic [CNT_W-1:0] BG_LAST  = CNT_W'(BG_PIXELS - 1);
  localparam logic [CNT_W-1:0] PAC_LAST = CNT_W'(PAC_PIXELS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic             sel_colour;

  // Everything visible to the sources and the mux decodes the registered
  // state only, so these outputs cannot glitch on input changes.
  assign bg_grant   = (state == ST_BG);
  assign pac_grant  = (state == ST_PAC);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign mux_select = bg_grant ? SEL_BG : (pac_grant ? SEL_PAC : SEL_NONE);

  assign accept     = (bg_grant & bg_valid) | (pac_grant & pac_valid);
  assign sel_x      = bg_grant ? x_bg      : x_pacman;
  assign sel_y      = bg_grant ? y_bg      : y_pacman;
  assign sel_colour = bg_grant ? colour_bg : colour_pacman;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // A tick is only honoured in IDLE; this includes the DONE cycle,
      // even though IDLE follows immediately.
      if (frame_tick && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (frame_tick) begin
          state_next = full_redraw ? ST_BG : ST_PAC;
          cnt_next   = '0;
        end
      end
      ST_BG: begin
        if (bg_valid) begin
          if (cnt == BG_LAST) begin
            state_next = ST_PAC;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_PAC: begin
        if (pac_valid) begin
          if (cnt == PAC_LAST) state_next = ST_DONE;
          else                 cnt_next   = cnt + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  vga_draw_scheduler_pixel_out_reg u_pixel_out (
    .clock      (clock),
    .resetn     (resetn),
    .load       (accept),
    .x          (sel_x),
    .y          (sel_y),
    .colour     (sel_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Self-checking bench for vga_draw_scheduler with BG_PIXELS=4, PAC_PIXELS=2.
// Each frame's stimulus is generated up front; the expected timeline is then
// derived from it (accept cycles = first N valid cycles of each phase) and
// compared against the DUT cycle by cycle.
module tb_vga_draw_scheduler;
  import vga_draw_scheduler_pkg::*;

  localparam int BG_P  = 4;
  localparam int PAC_P = 2;
  localparam int LEN   = 64;

  // clock / reset
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic           frame_tick, full_redraw;
  logic           bg_valid, colour_bg, bg_grant;
  logic [X_W-1:0] x_bg;
  logic [Y_W-1:0] y_bg;
  logic           pac_valid, colour_pacman, pac_grant;
  logic [X_W-1:0] x_pacman;
  logic [Y_W-1:0] y_pacman;
  logic [2:0]     mux_select;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic           vga_colour, plot, busy, frame_done, overrun;

  vga_draw_scheduler #(.BG_PIXELS(BG_P), .PAC_PIXELS(PAC_P)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .full_redraw   (full_redraw),
    .bg_valid      (bg_valid),
    .x_bg          (x_bg),
    .y_bg          (y_bg),
    .colour_bg     (colour_bg),
    .bg_grant      (bg_grant),
    .pac_valid     (pac_valid),
    .x_pacman      (x_pacman),
    .y_pacman      (y_pacman),
    .colour_pacman (colour_pacman),
    .pac_grant     (pac_grant),
    .mux_select    (mux_select),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .plot          (plot),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  // scoreboard state
  int          total;
  int          bad;
  logic [15:0] exp_q[$];
  logic [15:0] exp_px;
  logic        exp_ovr;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".bg_grant"},   16'(bg_grant),   16'd0);
    check({tag, ".pac_grant"},  16'(pac_grant),  16'd0);
    check({tag, ".mux_select"}, 16'(mux_select), 16'(SEL_NONE));
    check({tag, ".plot"},       16'(plot),       16'd0);
    check({tag, ".busy"},       16'(busy),       16'd0);
    check({tag, ".frame_done"}, 16'(frame_done), 16'd0);
    check({tag, ".overrun"},    16'(overrun),    16'(exp_ovr));
    check({tag, ".pixel"},      {vga_x, vga_y, vga_colour}, exp_px);
  endtask

  task automatic zero_inputs();
    frame_tick = 0; full_redraw = 0; bg_valid = 0; pac_valid = 0;
    x_bg = '0; y_bg = '0; colour_bg = 0;
    x_pacman = '0; y_pacman = '0; colour_pacman = 0;
  endtask

  // mode 0: always valid, 1: valid on odd cycles, 2: random (forced late)
  function automatic bit pat(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return i[0];
      default: return (i >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs one frame whose tick is driven in cycle 0.
  // tick_mode: 0 no extra tick, 1 extra tick at a random busy cycle,
  //            2 extra tick in the DONE cycle, 3 extra tick in cycle 2.
  // abort_c >= 0: reset is asserted in that cycle instead of finishing.
  task automatic run_frame(input bit full, input int bg_mode, input int pac_mode,
                           input int tick_mode, input int abort_c);
    bit          bgv[LEN], pacv[LEN], tk[LEN], acc[LEN];
    logic [15:0] bgw[LEN], pacw[LEN];
    int          n, c, pstart, last_bg, last_pac, done_c, last_c;
    bit          e_bg, e_pac;
    string       tag;
    for (int i = 0; i < LEN; i++) begin
      bgv[i]  = pat(bg_mode, i);
      pacv[i] = pat(pac_mode, i);
      bgw[i]  = {8'($urandom_range(0, SCREEN_W - 1)), 7'($urandom_range(0, SCREEN_H - 1)),
                 1'($urandom_range(0, 1))};
      pacw[i] = {8'($urandom_range(0, SCREEN_W - 1)), 7'($urandom_range(0, SCREEN_H - 1)),
                 1'($urandom_range(0, 1))};
      tk[i]   = 1'b0;
      acc[i]  = 1'b0;
    end
    tk[0] = 1'b1;
    // Background accepts: first BG_P cycles from cycle 1 with bg_valid.
    last_bg = 0;
    pstart  = 1;
    if (full) begin
      n = 0; c = 1;
      while (n < BG_P && c < LEN - 4) begin
        if (bgv[c]) begin acc[c] = 1'b1; n++; last_bg = c; end
        c++;
      end
      pstart = last_bg + 1;
    end
    // Sprite accepts: first PAC_P cycles from the sprite phase start.
    n = 0; c = pstart; last_pac = pstart;
    while (n < PAC_P && c < LEN - 3) begin
      if (pacv[c]) begin acc[c] = 1'b1; n++; last_pac = c; end
      c++;
    end
    done_c = last_pac + 1;
    case (tick_mode)
      1: tk[$urandom_range(1, done_c)] = 1'b1;
      2: tk[done_c] = 1'b1;
      3: tk[2] = 1'b1;
      default: ;
    endcase
    last_c = (abort_c >= 0) ? abort_c : done_c + 1;

    for (c = 0; c <= last_c; c++) begin
      @(negedge clock);
      tag   = $sformatf("f%0d.c%0d", full, c);
      e_bg  = full && c >= 1 && c <= last_bg;
      e_pac = c >= pstart && c <= last_pac;
      if (c >= 1 && acc[c - 1]) exp_px = exp_q.pop_front();
      check({tag, ".bg_grant"},   16'(bg_grant),   16'(e_bg));
      check({tag, ".pac_grant"},  16'(pac_grant),  16'(e_pac));
      check({tag, ".mux_select"}, 16'(mux_select),
            16'(e_bg ? SEL_BG : (e_pac ? SEL_PAC : SEL_NONE)));
      check({tag, ".plot"},       16'(plot),       16'(c >= 1 && acc[c - 1]));
      check({tag, ".busy"},       16'(busy),       16'(c >= 1 && c <= done_c));
      check({tag, ".frame_done"}, 16'(frame_done), 16'(c == done_c));
      check({tag, ".overrun"},    16'(overrun),    16'(exp_ovr));
      check({tag, ".pixel"},      {vga_x, vga_y, vga_colour}, exp_px);
      if (c == abort_c) begin
        zero_inputs();
        resetn = 1'b0;
        exp_q.delete();
        exp_px  = '0;
        exp_ovr = 1'b0;
        #1;
        check_idle("abort");
        #2 resetn = 1'b1;
        return;
      end
      // drive cycle c
      frame_tick    = tk[c];
      full_redraw   = (c == 0) ? full : 1'($urandom_range(0, 1));
      bg_valid      = bgv[c];
      {x_bg, y_bg, colour_bg} = bgw[c];
      pac_valid     = pacv[c];
      {x_pacman, y_pacman, colour_pacman} = pacw[c];
      if (acc[c]) exp_q.push_back(e_bg ? bgw[c] : pacw[c]);
      if (tk[c] && c >= 1 && c <= done_c) exp_ovr = 1'b1;
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_px  = '0;
    exp_ovr = 1'b0;
    zero_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check_idle("reset");
    resetn = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check_idle("idle");
    end

    run_frame(1'b1, 0, 0, 0, -1);   // full frame, sources always valid
    run_frame(1'b0, 0, 0, 0, -1);   // sprite-only frame
    run_frame(1'b1, 1, 0, 0, -1);   // gappy background, pac_valid high during BG
    run_frame(1'b1, 0, 0, 3, -1);   // tick mid-BG sets overrun
    run_frame(1'b1, 2, 2, 0, -1);   // overrun must stay set
    for (int k = 0; k < 6; k++)
      run_frame(1'($urandom_range(0, 1)), 2, 2, $urandom_range(0, 2), -1);

    run_frame(1'b1, 0, 0, 0, 3);    // reset after two BG accepts
    repeat (3) begin
      @(negedge clock);
      check_idle("post_abort");
    end
    run_frame(1'b1, 0, 0, 0, -1);   // restart takes the full 4 BG accepts
    run_frame(1'b1, 2, 2, 2, -1);   // tick in DONE cycle counts as overrun
    run_frame(1'b0, 2, 2, 0, -1);
    @(negedge clock);
    check_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
- Per-frame scheduler that shares the single VGA adapter write port between the background renderer and the pac-man sprite renderer.
- On each frame tick it grants the background source, then the pac-man source, and forwards accepted pixels to the adapter as registered x/y/colour/plot.
- It also drives the 3-bit source-select code used by the VGA mux, keeping that mux's encoding.
- Sits between the two renderers and the vga_adapter instance in the top level.

Parameters:
- BG_PIXELS, 19200, pixels per background pass (160x120); legal range 1..32767.
- PAC_PIXELS, 25, pixels per sprite pass (5x5); legal range 1..32767.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at frame rate
- full_redraw  in  1  sampled on accepted frame_tick; 1 = run background pass, 0 = sprite pass only
- bg_valid  in  1  background pixel present
- x_bg  in  8  background pixel x
- y_bg  in  7  background pixel y
- colour_bg  in  1  background pixel colour
- bg_grant  out  1  background source may stream
- pac_valid  in  1  pac-man pixel present
- x_pacman  in  8  pac-man pixel x
- y_pacman  in  7  pac-man pixel y
- colour_pacman  in  1  pac-man pixel colour
- pac_grant  out  1  pac-man source may stream
- mux_select  out  3  3'b000 = background, 3'b001 = pac-man, 3'b111 = idle
- vga_x  out  8  registered pixel x to adapter
- vga_y  out  7  registered pixel y to adapter
- vga_colour  out  1  registered pixel colour
- plot  out  1  adapter write enable
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- States: IDLE, BG, PAC, DONE. State register is asynchronously cleared to IDLE by resetn=0.
- Reset values:
  - all outputs 0, except mux_select = 3'b111;
  - pixel counter 0;
  - overrun 0.
- Transitions:
  - IDLE + frame_tick: go to BG if full_redraw=1, otherwise go to PAC. Counter cleared to 0.
  - BG: a pixel is accepted when bg_valid=1. On the accept with counter = BG_PIXELS-1, go to PAC and clear the counter.
  - PAC: a pixel is accepted when pac_valid=1. On the accept with counter = PAC_PIXELS-1, go to DONE.
  - DONE: go to IDLE after one cycle. frame_done=1 only during DONE.
- Grants and select are decoded from the registered state (glitch-free):
  - bg_grant = (state==BG);
  - pac_grant = (state==PAC);
  - mux_select = 000 in BG, 001 in PAC, 111 otherwise.
- Acceptance rule: accept = grant & valid of the granted source only. Valids from the non-granted source are ignored.
- Grant deasserts on the cycle after the final accept. No extra accept is possible at the phase boundary.
- Latency: a pixel accepted in cycle N appears on vga_x/vga_y/vga_colour with plot=1 in cycle N+1.
  - plot=0 in every cycle following a non-accept cycle.
  - vga_x/y/colour hold their last value while plot=0.
- Counter: 15 bits, unsigned. Increments by 1 per accept and never wraps; the terminal compare ends the phase.
- frame_tick while busy (BG, PAC or DONE): ignored; overrun set to 1. overrun clears only on reset.
- frame_tick in the same cycle the DONE→IDLE edge occurs: ignored, counted as overrun. The tick must be seen in IDLE to start a frame.
- Simultaneous bg_valid and pac_valid: the granted one wins; the other is ignored.
- Reset mid-frame: immediate return to IDLE.
  - Grants and plot drop asynchronously.
  - Partially drawn frame abandoned; no frame_done pulse.
- full_redraw is ignored outside the accepting frame_tick cycle.

Decomposition:
- Shared package/include:
  - state encodings (IDLE/BG/PAC/DONE);
  - mux_select codes SEL_BG=3'b000, SEL_PAC=3'b001, SEL_NONE=3'b111;
  - screen constants X_W=8, Y_W=7, SCREEN_W=160, SCREEN_H=120.
- One natural sub-module: pixel_out_reg. It holds the registered x/y/colour/plot stage with hold-on-idle and async clear. The FSM and counter stay in the top.

Test Plan (BG_PIXELS=4, PAC_PIXELS=2 unless stated):
- resetn low, then release, no tick → plot=0, grants=0, mux_select=111, busy=0 indefinitely.
- frame_tick with full_redraw=1, bg_valid held 1 → bg_grant high exactly 4 cycles, 4 plot pulses with x_bg values delayed 1 cycle. Then pac_grant; 2 plots of pacman pixels; frame_done pulse 1 cycle after last accept; mux_select sequence 000,000,000,000,001,001,111.
- full_redraw=0 tick → bg_grant never asserts; exactly 2 pac plots; frame_done.
- bg_valid toggling 1,0,1,0… → plot pulses only on accepts; 4 accepts take 7 cycles; vga_x holds during gaps; pac_valid=1 during BG produces no plot.
- frame_tick mid-BG → no restart, overrun=1 and stays 1 through the next frames until reset.
- resetn pulsed low after 2 BG accepts → outputs and grants zero immediately. A next tick restarts with the full 4 BG accepts; no frame_done from the aborted frame.
